// File: rtl/pd_isolation_sequencer.sv
// Always-on power sequencer for one switchable domain: drives switch, retention,
// domain reset and the output isolation clamp through fixed power-down/up sequences.
module pd_isolation_sequencer #(
  parameter int                DATA_W    = 8,
  parameter logic [DATA_W-1:0] ISO_CLAMP = '0,
  parameter int                PSW_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_down_req,
  input  logic [DATA_W-1:0] data_pd_i,
  output logic [DATA_W-1:0] data_ao_o,
  output logic              iso_en_o,
  output logic              save_o,
  output logic              restore_o,
  output logic              pd_rst_n_o,
  output logic              psw_en_o,
  output logic              domain_on_o,
  output logic              busy_o
);

  localparam int CNT_W = $clog2(PSW_WAIT + 1);

  localparam logic [3:0] ST_OFF     = 4'd0;
  localparam logic [3:0] ST_PSW_ON  = 4'd1;
  localparam logic [3:0] ST_RESTORE = 4'd2;
  localparam logic [3:0] ST_RST_REL = 4'd3;
  localparam logic [3:0] ST_ON      = 4'd4;
  localparam logic [3:0] ST_ISO     = 4'd5;
  localparam logic [3:0] ST_SAVE    = 4'd6;
  localparam logic [3:0] ST_RST     = 4'd7;
  localparam logic [3:0] ST_PSW_OFF = 4'd8;

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             retained_q, retained_d;

  logic iso_d, save_d, restore_d, pd_rst_n_d, psw_d, on_d, busy_d;

  // The request level is only looked at in the two resting states; every
  // sequence runs to completion once started.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    retained_d = retained_q;
    case (state_q)
      ST_OFF: begin
        if (!pwr_down_req) begin
          state_d = ST_PSW_ON;
          cnt_d   = CNT_W'(PSW_WAIT);
        end
      end
      ST_PSW_ON: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = retained_q ? ST_RESTORE : ST_RST_REL;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESTORE: state_d = ST_RST_REL;
      ST_RST_REL: state_d = ST_ON;
      ST_ON: begin
        if (pwr_down_req) begin
          state_d = ST_ISO;
        end
      end
      ST_ISO: state_d = ST_SAVE;
      ST_SAVE: begin
        state_d    = ST_RST;
        retained_d = 1'b1;
      end
      ST_RST: begin
        state_d = ST_PSW_OFF;
        cnt_d   = CNT_W'(PSW_WAIT);
      end
      ST_PSW_OFF: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Outputs are decoded from the next state so they change on the same edge
  // as the state register and come straight out of flops.
  always_comb begin
    iso_d      = 1'b1;
    save_d     = 1'b0;
    restore_d  = 1'b0;
    pd_rst_n_d = 1'b0;
    psw_d      = 1'b1;
    on_d       = 1'b0;
    busy_d     = 1'b1;
    case (state_d)
      ST_OFF: begin
        psw_d  = 1'b0;
        busy_d = 1'b0;
      end
      ST_PSW_ON:  ;
      ST_RESTORE: restore_d = 1'b1;
      ST_RST_REL: pd_rst_n_d = 1'b1;
      ST_ON: begin
        iso_d      = 1'b0;
        pd_rst_n_d = 1'b1;
        on_d       = 1'b1;
        busy_d     = 1'b0;
      end
      ST_ISO: pd_rst_n_d = 1'b1;
      ST_SAVE: begin
        pd_rst_n_d = 1'b1;
        save_d     = 1'b1;
      end
      ST_RST:     ;
      ST_PSW_OFF: psw_d = 1'b0;
      default: begin
        psw_d  = 1'b0;
        busy_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      retained_q  <= 1'b0;
      iso_en_o    <= 1'b1;
      save_o      <= 1'b0;
      restore_o   <= 1'b0;
      pd_rst_n_o  <= 1'b0;
      psw_en_o    <= 1'b0;
      domain_on_o <= 1'b0;
      busy_o      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      retained_q  <= retained_d;
      iso_en_o    <= iso_d;
      save_o      <= save_d;
      restore_o   <= restore_d;
      pd_rst_n_o  <= pd_rst_n_d;
      psw_en_o    <= psw_d;
      domain_on_o <= on_d;
      busy_o      <= busy_d;
    end
  end

  // Clamp selects on the registered enable, so an undriven domain never leaks through.
  assign data_ao_o = iso_en_o ? ISO_CLAMP : data_pd_i;

endmodule

// File: tb/tb_pd_isolation_sequencer.sv
// Bench for pd_isolation_sequencer: directed sequence timing plus randomized
// request/reset traffic against a queue-based sequence model.
module tb_pd_isolation_sequencer;

  localparam int DATA_W   = 8;
  localparam int PSW_WAIT = 4;

  // Output vector order: {psw, iso, pd_rst_n, save, restore, domain_on, busy}
  localparam logic [6:0] V_OFF     = 7'b0100000;
  localparam logic [6:0] V_PSW_ON  = 7'b1100001;
  localparam logic [6:0] V_RESTORE = 7'b1100101;
  localparam logic [6:0] V_RST_REL = 7'b1110001;
  localparam logic [6:0] V_ON      = 7'b1010010;
  localparam logic [6:0] V_ISO     = 7'b1110001;
  localparam logic [6:0] V_SAVE    = 7'b1111001;
  localparam logic [6:0] V_RST     = 7'b1100001;
  localparam logic [6:0] V_PSW_OFF = 7'b0100001;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              pwr_down_req;
  logic [DATA_W-1:0] data_pd_i;
  logic [DATA_W-1:0] data_ao_o;
  logic              iso_en_o, save_o, restore_o, pd_rst_n_o, psw_en_o, domain_on_o, busy_o;

  int errors = 0;
  int checks = 0;

  logic [6:0] cur;
  logic [6:0] seq[$];
  bit         retained;

  pd_isolation_sequencer #(
    .DATA_W(DATA_W),
    .ISO_CLAMP('0),
    .PSW_WAIT(PSW_WAIT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pwr_down_req(pwr_down_req),
    .data_pd_i(data_pd_i),
    .data_ao_o(data_ao_o),
    .iso_en_o(iso_en_o),
    .save_o(save_o),
    .restore_o(restore_o),
    .pd_rst_n_o(pd_rst_n_o),
    .psw_en_o(psw_en_o),
    .domain_on_o(domain_on_o),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [6:0] obsVec();
    return {psw_en_o, iso_en_o, pd_rst_n_o, save_o, restore_o, domain_on_o, busy_o};
  endfunction

  function automatic void modelReset();
    cur = V_OFF;
    seq.delete();
    retained = 1'b0;
  endfunction

  // A resting state that sees a request queues up the whole ordered sequence;
  // each later edge simply plays back the next entry.
  function automatic void modelStep();
    if (!rst_n) begin
      modelReset();
    end else begin
      if (seq.size() == 0 && cur == V_OFF && !pwr_down_req) begin
        repeat (PSW_WAIT) seq.push_back(V_PSW_ON);
        if (retained) seq.push_back(V_RESTORE);
        seq.push_back(V_RST_REL);
        seq.push_back(V_ON);
      end else if (seq.size() == 0 && cur == V_ON && pwr_down_req) begin
        seq.push_back(V_ISO);
        seq.push_back(V_SAVE);
        seq.push_back(V_RST);
        repeat (PSW_WAIT) seq.push_back(V_PSW_OFF);
        seq.push_back(V_OFF);
        retained = 1'b1;
      end
      if (seq.size() > 0) cur = seq.pop_front();
    end
  endfunction

  task automatic stepClock();
    logic [DATA_W-1:0] expData;
    @(posedge clk);
    modelStep();
    @(negedge clk);
    expData = cur[5] ? '0 : data_pd_i;
    checkOutput("outs", 32'(obsVec()), 32'(cur));
    checkOutput("data", 32'(data_ao_o), 32'(expData));
  endtask

  // mode 0: run until domain is on; mode 1: run until resting in OFF
  task automatic waitFor(input int mode, input int maxCycles, output int edges,
                         output int saves, output int restores);
    bit done;
    done = 1'b0;
    edges = 0;
    saves = 0;
    restores = 0;
    for (int i = 0; i < maxCycles && !done; i++) begin
      stepClock();
      edges++;
      saves += int'(save_o);
      restores += int'(restore_o);
      if (mode == 0) done = domain_on_o;
      else done = !busy_o && !domain_on_o;
    end
    if (!done) checkOutput("timeout", 32'(0), 32'(1));
  endtask

  task automatic applyStimulus();
    if (!rst_n) begin
      if ($urandom_range(1, 0) == 1) rst_n = 1'b1;
    end else if ($urandom_range(299, 0) == 0) begin
      rst_n = 1'b0;
      #1;
      modelReset();
      checkOutput("rand_async_rst", 32'(obsVec()), 32'(cur));
    end
    if ($urandom_range(7, 0) == 0) pwr_down_req = ~pwr_down_req;
    if (cur == V_OFF && $urandom_range(3, 0) == 0) data_pd_i = 'x;
    else data_pd_i = DATA_W'($urandom);
  endtask

  initial begin
    int edges, saves, restores;
    rst_n = 1'b0;
    pwr_down_req = 1'b0;
    data_pd_i = 8'h3C;
    modelReset();
    stepClock();
    stepClock();
    checkOutput("reset_outs", 32'(obsVec()), 32'(V_OFF));
    checkOutput("reset_clamp", 32'(data_ao_o), 32'(8'h00));

    rst_n = 1'b1;
    waitFor(0, 20, edges, saves, restores);
    checkOutput("first_up_edges", 32'(edges), 32'(PSW_WAIT + 2));
    checkOutput("first_up_restore", 32'(restores), 32'(0));

    data_pd_i = 8'hA5;
    stepClock();
    checkOutput("on_passthru", 32'(data_ao_o), 32'(8'hA5));

    pwr_down_req = 1'b1;
    waitFor(1, 20, edges, saves, restores);
    checkOutput("down_edges", 32'(edges), 32'(PSW_WAIT + 4));
    checkOutput("down_saves", 32'(saves), 32'(1));

    data_pd_i = 'x;
    repeat (3) stepClock();
    checkOutput("x_clamp", 32'(data_ao_o), 32'(8'h00));

    for (int n = 0; n < 2; n++) begin
      data_pd_i = 8'h5A;
      pwr_down_req = 1'b0;
      waitFor(0, 20, edges, saves, restores);
      checkOutput("up_ret_edges", 32'(edges), 32'(PSW_WAIT + 3));
      checkOutput("up_ret_restore", 32'(restores), 32'(1));
      pwr_down_req = 1'b1;
      waitFor(1, 20, edges, saves, restores);
      checkOutput("down_again_edges", 32'(edges), 32'(PSW_WAIT + 4));
    end

    pwr_down_req = 1'b0;
    waitFor(0, 20, edges, saves, restores);
    pwr_down_req = 1'b1;
    stepClock();
    stepClock();
    pwr_down_req = 1'b0;
    waitFor(1, 20, edges, saves, restores);
    checkOutput("toggle_edges", 32'(edges), 32'(PSW_WAIT + 2));
    stepClock();
    checkOutput("restart_psw", 32'(psw_en_o), 32'(1));
    stepClock();

    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("mid_rst_outs", 32'(obsVec()), 32'(V_OFF));
    stepClock();
    rst_n = 1'b1;
    waitFor(0, 20, edges, saves, restores);
    checkOutput("post_rst_edges", 32'(edges), 32'(PSW_WAIT + 2));
    checkOutput("post_rst_restore", 32'(restores), 32'(0));

    for (int i = 0; i < 1500; i++) begin
      applyStimulus();
      stepClock();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
